add_round_key: RTL and testbench

ADD_ROUND_KEY -- requirements
Module: add_round_key

---
 rtl/add_round_key_if.sv | 34 +++
 rtl/add_round_key.sv | 144 ++++++++++++++
 tb/tb_add_round_key.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_round_key_if.sv
// Handshake bundle for add_round_key: the round-key write port, the input state stream
// and the registered output stream.
interface add_round_key_if;
    logic         key_wr_en;
    logic [3:0]   key_wr_idx;
    logic [127:0] key_wr_data;

    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic [127:0] data_in;

    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic [3:0]   out_round;
    logic         out_last;

    modport master (
        output key_wr_en, key_wr_idx, key_wr_data,
        output in_valid, in_first, data_in,
        input  in_ready,
        input  out_valid, data_out, out_round, out_last,
        output out_ready
    );

    modport slave (
        input  key_wr_en, key_wr_idx, key_wr_data,
        input  in_valid, in_first, data_in,
        output in_ready,
        output out_valid, data_out, out_round, out_last,
        input  out_ready
    );
endinterface

// File: rtl/add_round_key.sv
// AES AddRoundKey stage: stores NUM_ROUNDS+1 round keys and XORs each accepted state word
// with the key of its round. Define ARK_SKID_BUFFER_EN for a registered-ready skid buffer.
module add_round_key #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic           clk,
    input  logic           n_rst,
    add_round_key_if.slave bus
);

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   round;
        logic         last;
    } ark_result_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    logic [127:0] key_q [NUM_ROUNDS+1];
    logic [127:0] key_d [NUM_ROUNDS+1];
    logic [127:0] key_sel;

    logic [3:0]   rnd_cnt_q, rnd_cnt_d;
    logic [3:0]   idx;
    logic         accept;
    logic         in_ready;
    ark_result_t  res_new;

    logic         out_valid_q, out_valid_d;
    ark_result_t  out_q, out_d;

    // Indices above NUM_ROUNDS match no entry, so such writes fall through untouched.
    genvar gi;
    generate
        for (gi = 0; gi <= NUM_ROUNDS; gi++) begin : g_key
            assign key_d[gi] = (bus.key_wr_en && (bus.key_wr_idx == 4'(gi)))
                             ? bus.key_wr_data : key_q[gi];
        end
    endgenerate

    // The key is read from the registered store, so a same-cycle write is seen one cycle later.
    always_comb begin
        idx     = bus.in_first ? 4'd0 : rnd_cnt_q;
        key_sel = '0;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (idx == 4'(i)) begin
                key_sel = key_q[i];
            end
        end
        res_new       = '0;
        res_new.data  = bus.data_in ^ key_sel;
        res_new.round = idx;
        res_new.last  = (idx == LAST_IDX);

        accept    = bus.in_valid && in_ready;
        rnd_cnt_d = rnd_cnt_q;
        if (accept) begin
            rnd_cnt_d = res_new.last ? 4'd0 : idx + 4'd1;
        end
    end

`ifdef ARK_SKID_BUFFER_EN
    logic         in_ready_q, in_ready_d;
    logic         skid_valid_q, skid_valid_d;
    ark_result_t  skid_q, skid_d;

    assign in_ready = in_ready_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (skid_valid_q) begin
            // No acceptance possible while full; refill the output from the skid entry.
            if (bus.out_ready) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || bus.out_ready) begin
                out_d       = res_new;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = res_new;
                skid_valid_d = 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            in_ready_q   <= 1'b1;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            in_ready_q   <= in_ready_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end
`else
    assign in_ready = !out_valid_q || bus.out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (accept) begin
            out_d       = res_new;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rnd_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                key_q[i] <= '0;
            end
        end else begin
            rnd_cnt_q   <= rnd_cnt_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                key_q[i] <= key_d[i];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = out_q.data;
    assign bus.out_round = out_q.round;
    assign bus.out_last  = out_q.last;

endmodule

// File: tb/tb_add_round_key.sv
// Self-checking bench for add_round_key: directed scenarios plus a randomized stall run
// scored against a queue-based reference model. Honours ARK_SKID_BUFFER_EN.
module tb_add_round_key;

    localparam int NR = 10;
`ifdef ARK_SKID_BUFFER_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_rst = 1'b0;

    add_round_key_if bus ();

    add_round_key #(.NUM_ROUNDS(NR)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   round;
        logic         last;
    } res_t;

    int           checks = 0;
    int           failures = 0;
    res_t         exp_q[$];
    res_t         obs_q[$];
    logic [127:0] m_key [16];
    int           m_rnd = 0;
    bit           acc_pending = 1'b0;

    // Reference model: observes the handshake half a cycle before each rising edge.
    always @(negedge clk) begin
        int   r;
        res_t e;
        res_t o;
        if (!n_rst) begin
            exp_q.delete();
            obs_q.delete();
            for (int i = 0; i < 16; i++) m_key[i] = '0;
            m_rnd       = 0;
            acc_pending = 1'b0;
        end else begin
            acc_pending = bus.in_valid && bus.in_ready;
            if (acc_pending) begin
                r       = bus.in_first ? 0 : m_rnd;
                e.data  = bus.data_in ^ m_key[r];
                e.round = 4'(r);
                e.last  = (r == NR);
                exp_q.push_back(e);
                m_rnd = (r == NR) ? 0 : r + 1;
            end
            if (bus.key_wr_en && (int'(bus.key_wr_idx) <= NR)) begin
                m_key[bus.key_wr_idx] = bus.key_wr_data;
            end
            if (bus.out_valid && bus.out_ready) begin
                o.data  = bus.data_out;
                o.round = bus.out_round;
                o.last  = bus.out_last;
                obs_q.push_back(o);
            end
        end
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.in_first    = 1'b0;
        bus.data_in     = '0;
        bus.key_wr_en   = 1'b0;
        bus.key_wr_idx  = '0;
        bus.key_wr_data = '0;
    endtask

    task automatic settle();
        idle_inputs();
        bus.out_ready = 1'b1;
        repeat (4) tick();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic write_key(input int k, input logic [127:0] v);
        bus.key_wr_en   = 1'b1;
        bus.key_wr_idx  = 4'(k);
        bus.key_wr_data = v;
        tick();
        bus.key_wr_en   = 1'b0;
    endtask

    task automatic send_word(input bit first, input logic [127:0] d);
        bit got;
        got          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_first = first;
        bus.data_in  = d;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            if (acc_pending) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL send_timeout: accepted=%0d required=1", got);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.out_ready = 1'b0;
        n_rst = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.data_out !== '0) begin failures++; $display("FAIL rst_data_out: got %h want 0", bus.data_out); end
        checks++; if (bus.out_round !== 4'd0 || bus.out_last !== 1'b0) begin
            failures++; $display("FAIL rst_round_last: got %0d/%b want 0/0", bus.out_round, bus.out_last);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready: got %b want 1", bus.in_ready); end
        tick();
        $display("test_reset done");
    endtask

    task automatic test_known_vector();
        logic [127:0] want;
        want = 128'h00102030405060708090a0b0c0d0e0f0;
        bus.out_ready = 1'b1;
        write_key(0, 128'h000102030405060708090a0b0c0d0e0f);
        send_word(1'b1, 128'h00112233445566778899aabbccddeeff);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL vec_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.data_out !== want) begin failures++; $display("FAIL vec_data: got %h want %h", bus.data_out, want); end
        checks++; if (bus.out_round !== 4'd0 || bus.out_last !== 1'b0) begin
            failures++; $display("FAIL vec_round: got %0d/%b want 0/0", bus.out_round, bus.out_last);
        end
        settle();
        $display("test_known_vector data_out=%h", want);
    endtask

    task automatic test_round_sequence();
        int           r;
        logic [127:0] want;
        bus.out_ready = 1'b1;
        for (int k = 0; k <= NR; k++) write_key(k, {16{8'(k)}});
        for (int w = 0; w < 12; w++) send_word(w == 0, '0);
        idle_inputs();
        repeat (3) tick();
        checks++; if (obs_q.size() != 12) begin failures++; $display("FAIL seq_count: got %0d want 12", obs_q.size()); end
        for (int w = 0; w < obs_q.size() && w < 12; w++) begin
            r    = (w == 11) ? 0 : w;
            want = {16{8'(r)}};
            checks++;
            if (obs_q[w].data !== want || obs_q[w].round !== 4'(r) || obs_q[w].last !== (r == NR)) begin
                failures++;
                $display("FAIL seq_word%0d: got %h/%0d/%b want %h/%0d/%b", w,
                         obs_q[w].data, obs_q[w].round, obs_q[w].last, want, r, (r == NR));
            end
        end
        settle();
        $display("test_round_sequence words=12");
    endtask

    task automatic test_stall();
        int           acc;
        bit           have_ref;
        logic [127:0] ref_data;
        logic [3:0]   ref_round;
        acc      = 0;
        have_ref = 1'b0;
        ref_data = '0;
        ref_round = '0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_first  = 1'b1;
        bus.data_in   = rand128();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            if (acc_pending) acc++;
            #1;
            if (acc_pending) begin
                bus.data_in  = rand128();
                bus.in_first = 1'b0;
            end
            @(negedge clk);
            if (bus.out_valid) begin
                if (!have_ref) begin
                    ref_data  = bus.data_out;
                    ref_round = bus.out_round;
                    have_ref  = 1'b1;
                end else begin
                    checks++;
                    if (bus.data_out !== ref_data || bus.out_round !== ref_round) begin
                        failures++;
                        $display("FAIL stall_hold: got %h/%0d want %h/%0d", bus.data_out, bus.out_round, ref_data, ref_round);
                    end
                end
            end
        end
        checks++; if (acc != (SKID ? 2 : 1)) begin failures++; $display("FAIL stall_accepts: got %0d want %0d", acc, SKID ? 2 : 1); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        idle_inputs();
        bus.out_ready = 1'b1;
        repeat (5) tick();
        checks++; if (obs_q.size() != acc || exp_q.size() != acc) begin
            failures++; $display("FAIL stall_delivered: got %0d model %0d want %0d", obs_q.size(), exp_q.size(), acc);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] != exp_q[i]) begin
                failures++;
                $display("FAIL stall_word%0d: got %h/%0d want %h/%0d", i, obs_q[i].data, obs_q[i].round, exp_q[i].data, exp_q[i].round);
            end
        end
        settle();
        $display("test_stall accepted=%0d", acc);
    endtask

    task automatic test_same_cycle_key();
        logic [127:0] aa;
        logic [127:0] five;
        bit           got;
        aa   = {16{8'hAA}};
        five = {16{8'h55}};
        bus.out_ready = 1'b1;
        write_key(0, '0);
        bus.key_wr_en   = 1'b1;
        bus.key_wr_idx  = 4'd0;
        bus.key_wr_data = '1;
        bus.in_valid    = 1'b1;
        bus.in_first    = 1'b1;
        bus.data_in     = aa;
        @(posedge clk);
        got = acc_pending;
        #1;
        idle_inputs();
        checks++; if (!got) begin failures++; $display("FAIL samecyc_accept: got %b want 1", got); end
        checks++; if (bus.data_out !== aa) begin failures++; $display("FAIL samecyc_old_key: got %h want %h", bus.data_out, aa); end
        send_word(1'b1, aa);
        checks++; if (bus.data_out !== five || bus.out_round !== 4'd0) begin
            failures++; $display("FAIL samecyc_new_key: got %h/%0d want %h/0", bus.data_out, bus.out_round, five);
        end
        settle();
        $display("test_same_cycle_key done");
    endtask

    task automatic test_reset_mid_block();
        logic [127:0] d;
        bus.out_ready = 1'b1;
        for (int k = 0; k <= NR; k++) write_key(k, rand128() | 128'h1);
        for (int w = 0; w < 5; w++) send_word(w == 0, rand128());
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.data_in   = rand128();
        tick();
        n_rst = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
        @(posedge clk); #1;
        n_rst = 1'b1;
        idle_inputs();
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_output: got %b want 0", bus.out_valid); end
        d = rand128();
        send_word(1'b0, d);
        checks++; if (bus.data_out !== d || bus.out_round !== 4'd0) begin
            failures++; $display("FAIL midrst_restart: got %h/%0d want %h/0", bus.data_out, bus.out_round, d);
        end
        settle();
        $display("test_reset_mid_block done");
    endtask

    task automatic test_random_stall();
        int acc;
        acc = 0;
        bus.out_ready = 1'b1;
        write_key(15, '1);
        write_key(11, rand128());
        for (int k = 0; k <= NR; k++) write_key(k, rand128());
        for (int cyc = 0; cyc < 20000 && acc < 1000; cyc++) begin
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.in_first    = ($urandom_range(0, 19) == 0);
            bus.data_in     = rand128();
            bus.out_ready   = ($urandom_range(0, 2) != 0);
            bus.key_wr_en   = ($urandom_range(0, 15) == 0);
            bus.key_wr_idx  = 4'($urandom_range(0, 15));
            bus.key_wr_data = rand128();
            @(posedge clk);
            if (acc_pending) acc++;
            #1;
        end
        idle_inputs();
        bus.out_ready = 1'b1;
        repeat (5) tick();
        checks++; if (acc < 1000) begin failures++; $display("FAIL rand_budget: got %0d want 1000", acc); end
        checks++; if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] != exp_q[i]) begin
                failures++;
                $display("FAIL rand_word%0d: got %h/%0d/%b want %h/%0d/%b", i, obs_q[i].data, obs_q[i].round,
                         obs_q[i].last, exp_q[i].data, exp_q[i].round, exp_q[i].last);
            end
        end
        settle();
        $display("test_random_stall words=%0d", acc);
    endtask

    initial begin
        idle_inputs();
        bus.out_ready = 1'b0;
        test_reset();
        test_known_vector();
        test_round_sequence();
        test_stall();
        test_same_cycle_key();
        test_reset_mid_block();
        test_random_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
